// File: rtl/friet_lwc_buffer_out.sv
// Two-entry output buffer (head + skid) between the FRIET core and the LWC data-out port.
// din_ready is a function of registered occupancy only, so dout_ready never reaches the core combinationally.
module friet_lwc_buffer_out #(
    parameter int unsigned G_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [G_WIDTH-1:0] din,
    input  logic               din_last,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [G_WIDTH-1:0] dout,
    output logic               dout_last,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               buffer_empty
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2,
        ST_ILL   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [G_WIDTH:0]   r_head;
    logic [G_WIDTH:0]   r_skid;
    logic [G_WIDTH:0]   w_head_next;
    logic [G_WIDTH:0]   w_skid_next;
    logic [G_WIDTH:0]   w_din_word;
    logic               w_push;
    logic               w_pop;

    assign w_din_word   = {din_last, din};
    assign din_ready    = rst & (r_state != ST_TWO);
    assign dout_valid   = (r_state != ST_EMPTY);
    assign buffer_empty = (r_state == ST_EMPTY);
    assign dout         = r_head[G_WIDTH-1:0];
    assign dout_last    = r_head[G_WIDTH];
    assign w_push       = din_valid & din_ready;
    assign w_pop        = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else if (rst) begin
            r_state <= w_state_next;
        end else begin
            r_state <= state_t'('x);
        end
    end

    // Data registers carry no reset; they are only meaningful while dout_valid is high.
    always_ff @(posedge clk) begin
        r_head <= w_head_next;
        r_skid <= w_skid_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_skid_next  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_head_next  = w_din_word;
                    w_state_next = ST_ONE;
                end else if (!w_push) begin
                    w_state_next = ST_EMPTY;
                end else begin
                    w_state_next = state_t'('x);
                    w_head_next  = 'x;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_head_next  = w_din_word;
                    w_state_next = ST_ONE;
                end else if (w_push && !w_pop) begin
                    w_skid_next  = w_din_word;
                    w_state_next = ST_TWO;
                end else if (!w_push && w_pop) begin
                    w_state_next = ST_EMPTY;
                end else if (!w_push && !w_pop) begin
                    w_state_next = ST_ONE;
                end else begin
                    w_state_next = state_t'('x);
                    w_head_next  = 'x;
                    w_skid_next  = 'x;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_head_next  = r_skid;
                    w_state_next = ST_ONE;
                end else if (!w_pop) begin
                    w_state_next = ST_TWO;
                end else begin
                    w_state_next = state_t'('x);
                    w_head_next  = 'x;
                end
            end
            ST_ILL: begin
                w_state_next = ST_EMPTY;
            end
            default: begin
                w_state_next = state_t'('x);
                w_head_next  = 'x;
                w_skid_next  = 'x;
            end
        endcase
    end

endmodule

// File: tb/tb_friet_lwc_buffer_out.sv
// Bench for friet_lwc_buffer_out: directed scenarios plus random traffic,
// all checked against a capacity-2 FIFO queue model.
module tb_friet_lwc_buffer_out;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_last;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] dout;
    logic         dout_last;
    logic         dout_valid;
    logic         dout_ready;
    logic         buffer_empty;

    int unsigned  tests = 0;
    int unsigned  fails = 0;

    logic [W:0]   q[$];
    bit           known = 1'b0;

    friet_lwc_buffer_out #(.G_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_last     (din_last),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .dout         (dout),
        .dout_last    (dout_last),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .buffer_empty (buffer_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model at the edge.
    task automatic step(input logic r, input logic [W-1:0] d, input logic l,
                        input logic v, input logic rd);
        bit do_push;
        bit do_pop;
        rst        = r;
        din        = d;
        din_last   = l;
        din_valid  = v;
        dout_ready = rd;
        #1;
        if (!r) chk("din_ready_in_reset", {63'd0, din_ready}, 64'd0);
        else if (known) chk("din_ready", {63'd0, din_ready}, {63'd0, q.size() < 2});
        if (known) begin
            chk("dout_valid", {63'd0, dout_valid}, {63'd0, q.size() != 0});
            chk("buffer_empty", {63'd0, buffer_empty}, {63'd0, q.size() == 0});
            if (q.size() != 0) begin
                chk("dout", {32'd0, dout}, {32'd0, q[0][W-1:0]});
                chk("dout_last", {63'd0, dout_last}, {63'd0, q[0][W]});
            end
        end
        @(posedge clk);
        if (!r) begin
            q.delete();
            known = 1'b1;
        end else if (known) begin
            do_push = v && (q.size() < 2);
            do_pop  = rd && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({l, d});
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset then idle
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0, 1'b0);
        chk("idle_empty", {63'd0, buffer_empty}, 64'd1);
        chk("idle_din_ready", {63'd0, din_ready}, 64'd1);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++)
            step(1'b1, W'(i), (i == 8), 1'b1, 1'b1);
        chk("stream_last_word", {32'd0, dout}, 64'h8);
        chk("stream_last_flag", {63'd0, dout_last}, 64'd1);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);

        // Back-pressure fill, then drain in order
        step(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
        chk("bp_full_ready", {63'd0, din_ready}, 64'd0);
        chk("bp_hold_head", {32'd0, dout}, 64'hA);
        step(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        chk("bp_still_head", {32'd0, dout}, 64'hA);
        step(1'b1, 32'hC, 1'b0, 1'b1, 1'b1);
        chk("drain_b", {32'd0, dout}, 64'hB);
        step(1'b1, 32'hC, 1'b1, 1'b1, 1'b1);
        chk("drain_c", {32'd0, dout}, 64'hC);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        chk("drain_empty", {63'd0, buffer_empty}, 64'd1);

        // Simultaneous push/pop while holding one word
        step(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b1, 1'b1);
        chk("pp_dout", {32'd0, dout}, 64'h22);
        chk("pp_one_ready", {63'd0, din_ready}, 64'd1);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);

        // Reset while full discards held words
        step(1'b1, 32'h5, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h6, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h9, 1'b0, 1'b1, 1'b1);
        chk("rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("rst_empty", {63'd0, buffer_empty}, 64'd1);
        step(1'b1, 32'h7, 1'b1, 1'b1, 1'b0);
        chk("rst_next_word", {32'd0, dout}, 64'h7);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) != 0), $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/friet_lwc_buffer_out.md
Name: friet_lwc_buffer_out

Overview:
- Two-entry output buffer between the FRIET core datapath and the LWC data-out port. It is the transmit-side counterpart of the single-entry input buffer.
- Accepts words with a last-word flag from the core and presents them to the external consumer over a valid/ready handshake.
- Sustains one word per cycle.
- din_ready depends only on registered state. There is no combinational path from dout_ready to din_ready, so the core never sees the external ready in the same cycle.

Parameters:
- G_WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- din  input  G_WIDTH  data word from the core.
- din_last  input  1  marks the final word of a message segment; travels with din.
- din_valid  input  1  din/din_last are valid.
- din_ready  output  1  buffer can accept a word this cycle.
- dout  output  G_WIDTH  data word to the LWC port.
- dout_last  output  1  last flag belonging to dout.
- dout_valid  output  1  dout/dout_last are valid.
- dout_ready  input  1  consumer accepts dout this cycle.
- buffer_empty  output  1  high when no word is held; used by the top level to detect a completed flush.

Behaviour:
- Storage:
  - head register (data+last) drives dout/dout_last directly.
  - skid register (data+last).
  - 2-bit occupancy state: EMPTY(0), ONE(1), TWO(2). Encoding 3 is illegal and recovers to EMPTY.
- Handshake events:
  - push = din_valid & din_ready.
  - pop = dout_valid & dout_ready.
- Combinational outputs:
  - dout_valid = (state != EMPTY).
  - buffer_empty = (state == EMPTY).
  - din_ready = rst & (state != TWO).
  - dout_valid depends only on state.
- Transitions on the clock edge, with rst=1:
  - EMPTY, push: head <= din; go to ONE.
  - EMPTY, no push: stay.
  - ONE, push & pop: head <= din; stay ONE (full-throughput case).
  - ONE, push only: skid <= din; go to TWO.
  - ONE, pop only: go to EMPTY.
  - ONE, neither: hold.
  - TWO, pop: head <= skid; go to ONE. push is impossible because din_ready=0.
  - TWO, no pop: hold all.
- Ordering is strictly FIFO. dout_last always stays paired with its own word.
- Latency: a word pushed in cycle N is visible on dout in cycle N+1 at the earliest.
- Throughput: with dout_ready held high, one word per cycle indefinitely, and the buffer never reaches TWO.
- Back-pressure:
  - After dout_ready drops, at most one further word is accepted, going into skid.
  - din_ready drops in the following cycle.
- Reset:
  - rst=0 sampled at an edge forces state to EMPTY. This applies from any state, including mid-transfer, and any held words are discarded.
  - While rst=0, din_ready=0, so no push is counted.
  - dout_valid reflects the registered state and is 0 from the first edge after rst is asserted.
- Data registers (head, skid) are not reset. dout/dout_last are don't-care while dout_valid=0.
- Every if/case in the RTL has an explicit else branch that drives x on undefined inputs (x-propagation for simulation).

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then rst=1 with din_valid=0 -> dout_valid=0, buffer_empty=1, din_ready=1. din_ready=0 on every cycle with rst=0.
2. Streaming: dout_ready=1; push 0x00000001..0x00000008 on consecutive cycles, last=1 on 0x08 -> the same 8 words appear on 8 consecutive cycles starting 1 cycle after the first push. din_ready stays 1. dout_last=1 only on 0x08.
3. Back-pressure fill: dout_ready=0; push 0xA, then 0xB -> state TWO, din_ready=0 next cycle, dout=0xA held stable. A third word 0xC held on din is not accepted.
4. Drain: from scenario 3, raise dout_ready -> pops 0xA, then 0xB (taken from skid), then 0xC once din_ready returns. Order is A, B, C and buffer_empty=1 afterwards.
5. Simultaneous push/pop in ONE: hold 0x11, push 0x22 while popping -> next cycle dout=0x22, state ONE, no word lost or duplicated.
6. Reset mid-operation: state TWO holding 0x5,0x6; assert rst=0 for one edge -> dout_valid=0, buffer_empty=1. After rst=1, pushing 0x7 makes 0x7 the next word out, and 0x5/0x6 never appear.
